almacenamiento_doble: RTL

Parametrised, double-buffered register storage between the RTC controller (writer) and the VGA character generator (reader). The writer fills a hidden back bank word by word and commits it atomically. The reader always sees a complete, consistent snapshot in the front bank, with a registered 1-cycle read. It replaces fixed-size combinational storage with sized, clocked storage that has a commit handshake and completeness checking.

---
 rtl/almacenamiento_doble.sv | 123 ++++++++++++
 1 files changed

// File: rtl/almacenamiento_doble.sv
// almacenamiento_doble: double-buffered register storage between a word-by-word writer
// (RTC controller) and a reader (VGA character generator).
//
// The writer fills the hidden back bank and then requests a commit, which swaps the banks
// atomically. The reader only ever sees the front bank, through a registered 1-cycle read.
//
// Parameters
//   DATA_W      width of each stored word
//   ADDR_W      address width of both ports
//   DEPTH       number of valid entries (1 <= DEPTH <= 2**ADDR_W)
//   FULL_COMMIT 1: commit only once every entry has been rewritten; 0: always commit
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   wr_en, wr_addr, wr_data   write into the back bank (out-of-range addresses ignored)
//   commit                    request to swap front and back banks
//   rd_en, rd_addr            read request from the front bank
//   rd_data, rd_valid         registered read result (0 for out-of-range addresses)
//   front                     index of the current front bank
//   full                      every entry written since the last accepted commit
//   commit_ack, commit_err    1-cycle result pulses for a commit request
module almacenamiento_doble #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FULL_COMMIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              front,
  output logic              full,
  output logic              commit_ack,
  output logic              commit_err
);

  logic [DATA_W-1:0] bank0_q [DEPTH];
  logic [DATA_W-1:0] bank1_q [DEPTH];
  logic [DEPTH-1:0]  dirty_q;
  logic [DEPTH-1:0]  dirty_d;
  logic [DEPTH-1:0]  wr_sel;
  logic              front_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_word;
  logic              commit_ok;
  logic              swap;

  // Address decode by matching against each valid entry: addresses at or beyond DEPTH
  // match nothing, so out-of-range writes are dropped and out-of-range reads return 0.
  always_comb begin
    wr_sel  = '0;
    rd_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        wr_sel[i] = 1'b1;
      end
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = front_q ? bank1_q[i] : bank0_q[i];
      end
    end
  end

  // Acceptance looks at the mask including this cycle's write, so the last word may
  // arrive together with the commit.
  always_comb begin
    dirty_d   = dirty_q | wr_sel;
    commit_ok = (FULL_COMMIT == 0) || (&dirty_d);
    swap      = commit && commit_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
      dirty_q    <= '0;
      front_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Writes target the pre-swap back bank, so a same-cycle commit exposes them.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          if (front_q) begin
            bank0_q[i] <= wr_data;
          end else begin
            bank1_q[i] <= wr_data;
          end
        end
      end
      dirty_q    <= swap ? '0 : dirty_d;
      front_q    <= front_q ^ swap;
      ack_q      <= swap;
      err_q      <= commit && !commit_ok;
      // rd_word is decoded from the pre-swap front bank.
      if (rd_en) begin
        rd_data_q <= rd_word;
      end
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign front      = front_q;
  assign full       = &dirty_q;
  assign commit_ack = ack_q;
  assign commit_err = err_q;

endmodule
